// File: rtl/systolic_pkg.sv
// systolic_pkg: frame layout, config address map and driver state shared by the host driver
package systolic_pkg;
  localparam int N_PE = 4;
  localparam int N_DATA = 7;
  localparam int FRAME_LEN = 17;
  localparam int CAPTURE_PHASE = 16;
  localparam int N_STG = 2 * N_PE + N_DATA;
  localparam logic [4:0] PH_IDLE = 5'd0;
  localparam logic [4:0] PH_W0 = 5'd1;
  localparam logic [4:0] PH_B0 = 5'd5;
  localparam logic [4:0] PH_D0 = 5'd9;
  localparam logic [4:0] PH_DRAIN = 5'd16;
  localparam logic [3:0] ADDR_W0 = 4'd0;
  localparam logic [3:0] ADDR_B0 = 4'd4;
  localparam logic [3:0] ADDR_D0 = 4'd8;
  typedef enum logic [1:0] {DRV_IDLE, DRV_ARMED, DRV_ACTIVE} drv_state_e;
endpackage

// File: rtl/systolic_frame_timer.sv
// systolic_frame_timer: free-running frame phase counter; slot decode describes the phase about to begin
module systolic_frame_timer
  import systolic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] phase_o,
  output logic       is_w_o,
  output logic       is_b_o,
  output logic       is_d_o,
  output logic       is_drain_o,
  output logic [3:0] index_o
);
  logic [4:0] phase_q, phase_d;
  assign phase_d = phase_q == PH_DRAIN ? PH_IDLE : phase_q + 5'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= PH_IDLE;
    else phase_q <= phase_d;
  end
  assign phase_o = phase_q;
  assign is_drain_o = phase_q == PH_DRAIN;
  // Decoding the next phase lets the driver register array_in with no extra latency
  assign is_w_o = phase_d >= PH_W0 && phase_d < PH_B0;
  assign is_b_o = phase_d >= PH_B0 && phase_d < PH_D0;
  assign is_d_o = phase_d >= PH_D0 && phase_d < PH_DRAIN;
  assign index_o = is_d_o ? 4'(phase_d - PH_D0) : is_b_o ? 4'(phase_d - PH_B0) : 4'(phase_d - PH_W0);
endmodule

// File: rtl/systolic_host_driver.sv
// systolic_host_driver: streams double-buffered operands to the array in frame lockstep and captures results
module systolic_host_driver
  import systolic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        start,
  output logic        busy,
  output logic [7:0]  array_in,
  input  logic [15:0] array_res,
  output logic [15:0] result_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic [4:0]  frame_phase
);
  logic is_w, is_b, is_d, is_drain;
  logic [3:0] idx, slot;
  logic [7:0] stg_q [N_STG];
  logic [7:0] shd_q [N_STG];
  logic armed_q, armed_d, active_q, active_d, valid_q, valid_d, ovf_q, ovf_d;
  logic [7:0] arr_q, arr_d;
  logic [15:0] res_q, res_d;
  logic begin_f, cap;
  drv_state_e state;
  systolic_frame_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_o   (frame_phase),
    .is_w_o    (is_w),
    .is_b_o    (is_b),
    .is_d_o    (is_d),
    .is_drain_o(is_drain),
    .index_o   (idx)
  );
  assign begin_f = frame_phase == PH_IDLE && armed_q;
  assign cap = active_q && frame_phase == 5'(CAPTURE_PHASE);
  assign slot = is_w ? ADDR_W0 + idx : is_b ? ADDR_B0 + idx : ADDR_D0 + idx;
  // On the starting edge the shadow is still being loaded, so read staging directly
  assign arr_d = (begin_f || active_q) && (is_w || is_b || is_d) ? (begin_f ? stg_q[slot] : shd_q[slot]) : 8'h00;
  assign armed_d = start | (armed_q & ~begin_f);
  assign active_d = begin_f | (active_q & ~is_drain);
  assign valid_d = cap | (valid_q & ~result_ready);
  assign ovf_d = (cap & valid_q & ~result_ready) | (ovf_q & ~overflow_clr);
  assign res_d = cap ? array_res : res_q;
  assign state = active_q ? DRV_ACTIVE : armed_q ? DRV_ARMED : DRV_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      active_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      arr_q <= 8'h00;
      res_q <= 16'h0000;
      for (int i = 0; i < N_STG; i++) begin
        stg_q[i] <= 8'h00;
        shd_q[i] <= 8'h00;
      end
    end else begin
      armed_q <= armed_d;
      active_q <= active_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      arr_q <= arr_d;
      res_q <= res_d;
      if (begin_f) shd_q <= stg_q;
      if (cfg_we && cfg_addr < 4'(N_STG)) stg_q[cfg_addr] <= cfg_wdata;
    end
  end
  assign busy = state != DRV_IDLE;
  assign array_in = arr_q;
  assign result_data = res_q;
  assign result_valid = valid_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_systolic_host_driver.sv
// tb_systolic_host_driver: directed frame-level checks of the host driver against hand-computed bytes
module tb_systolic_host_driver;
  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, start = 1'b0, result_ready = 1'b0, overflow_clr = 1'b0;
  logic [3:0] cfg_addr = 4'd0;
  logic [7:0] cfg_wdata = 8'h00;
  logic [15:0] res_word = 16'h0000;
  logic [15:0] array_res, result_data;
  logic busy, result_valid, overflow;
  logic [7:0] array_in;
  logic [4:0] frame_phase;
  int errors = 0, checks = 0, ph = 0;
  logic [7:0] basic_exp [15] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
                                 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
  systolic_host_driver dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy), .array_in(array_in), .array_res(array_res),
    .result_data(result_data), .result_valid(result_valid), .result_ready(result_ready),
    .overflow(overflow), .overflow_clr(overflow_clr), .frame_phase(frame_phase)
  );
  assign array_res = res_word;
  always #5 clk = ~clk;
  // Independent phase reference mirroring the controller's free-running frame
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ph <= 0;
    else ph <= (ph == 16) ? 0 : ph + 1;

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ph != p && n < 40);
    if (ph != p) begin
      checks++; errors++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", p, ph);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stage_all();
    for (int i = 0; i < 16; i++) begin
      cfg_we = 1'b1;
      cfg_addr = 4'(i);
      cfg_wdata = (i < 15) ? basic_exp[i] : 8'hFF;
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, array_in, result_data, result_valid, overflow, frame_phase} !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b in=%h data=%h valid=%b ovf=%b ph=%0d expected all zero",
               busy, array_in, result_data, result_valid, overflow, frame_phase);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_phase !== 5'd1) begin
      errors++;
      $display("FAIL reset_first_phase: got %0d expected 1", frame_phase);
    end
  endtask

  task automatic test_basic_frame();
    stage_all();
    res_word = 16'hBEEF;
    result_ready = 1'b0;
    wait_phase(5);
    pulse_start();
    checks++;
    if ({busy, array_in} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL armed_state: got busy=%b in=%h expected busy=1 in=00", busy, array_in);
    end
    wait_phase(1);
    for (int k = 1; k <= 16; k++) begin
      logic [7:0] e;
      e = (k < 16) ? basic_exp[k-1] : 8'h00;
      checks++;
      if ({busy, frame_phase, array_in} !== {1'b1, 5'(k), e}) begin
        errors++;
        $display("FAIL basic_stream k=%0d: got busy=%b ph=%0d in=%h expected busy=1 ph=%0d in=%h",
                 k, busy, frame_phase, array_in, k, e);
      end
      if (k < 16) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if ({busy, result_valid, result_data, overflow} !== {1'b0, 1'b1, 16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL basic_capture: got busy=%b valid=%b data=%h ovf=%b expected 0 1 beef 0",
               busy, result_valid, result_data, overflow);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if ({result_valid, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL ready_clears: got valid=%b ovf=%b expected 0 0", result_valid, overflow);
    end
  endtask

  task automatic test_double_buffer();
    result_ready = 1'b1;
    res_word = 16'hC0DE;
    wait_phase(3);
    pulse_start();
    wait_phase(1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 2 || k == 11) begin
        checks++;
        if (array_in !== (k == 2 ? 8'h02 : 8'hA2)) begin
          errors++;
          $display("FAIL dbuf_current k=%0d: got %h expected %h", k, array_in, k == 2 ? 8'h02 : 8'hA2);
        end
      end
      cfg_we = (k == 3 || k == 4);
      cfg_addr = (k == 3) ? 4'd1 : 4'd10;
      cfg_wdata = (k == 3) ? 8'h55 : 8'h77;
      if (k < 16) @(negedge clk);
    end
    cfg_we = 1'b0;
    wait_phase(3);
    pulse_start();
    wait_phase(1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 2 || k == 3 || k == 11) begin
        logic [7:0] e;
        e = (k == 2) ? 8'h55 : (k == 3) ? 8'h03 : 8'h77;
        checks++;
        if (array_in !== e) begin
          errors++;
          $display("FAIL dbuf_next k=%0d: got %h expected %h", k, array_in, e);
        end
      end
      if (k < 16) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if ({result_valid, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL dbuf_consumed: got valid=%b ovf=%b expected 0 0", result_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    res_word = 16'hAAAA;
    wait_phase(2);
    pulse_start();
    wait_phase(1);
    wait_phase(10);
    pulse_start();
    wait_phase(0);
    res_word = 16'h1234;
    checks++;
    if ({busy, result_valid, result_data, overflow} !== {1'b1, 1'b1, 16'hAAAA, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: got busy=%b valid=%b data=%h ovf=%b expected 1 1 aaaa 0",
               busy, result_valid, result_data, overflow);
    end
    @(negedge clk);
    checks++;
    if ({frame_phase, array_in} !== {5'd1, 8'h01}) begin
      errors++;
      $display("FAIL b2b_restart: got ph=%0d in=%h expected ph=1 in=01", frame_phase, array_in);
    end
    @(negedge clk);
    checks++;
    if (array_in !== 8'h55) begin
      errors++;
      $display("FAIL b2b_weight1: got %h expected 55", array_in);
    end
    wait_phase(16);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++;
    if ({busy, result_valid, result_data, overflow} !== {1'b0, 1'b1, 16'h1234, 1'b1}) begin
      errors++;
      $display("FAIL b2b_overflow: got busy=%b valid=%b data=%h ovf=%b expected 0 1 1234 1",
               busy, result_valid, result_data, overflow);
    end
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++;
    if ({overflow, result_valid} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b valid=%b expected ovf=0 valid=1", overflow, result_valid);
    end
  endtask

  task automatic test_capture_with_ready();
    res_word = 16'h5678;
    wait_phase(3);
    pulse_start();
    wait_phase(1);
    wait_phase(16);
    result_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({result_valid, result_data, overflow} !== {1'b1, 16'h5678, 1'b0}) begin
      errors++;
      $display("FAIL capture_wins: got valid=%b data=%h ovf=%b expected 1 5678 0",
               result_valid, result_data, overflow);
    end
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL capture_consumed: got valid=%b expected 0", result_valid);
    end
  endtask

  task automatic test_idle_frames();
    for (int i = 0; i < 51; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, array_in, result_valid} !== 10'h0) begin
        errors++;
        $display("FAIL idle_quiet cycle=%0d: got busy=%b in=%h valid=%b expected 0 00 0",
                 i, busy, array_in, result_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    res_word = 16'h9ABC;
    wait_phase(3);
    pulse_start();
    wait_phase(1);
    wait_phase(16);
    @(negedge clk);
    start = 1'b1;
    checks++;
    if ({result_valid, result_data} !== {1'b1, 16'h9ABC}) begin
      errors++;
      $display("FAIL pre_reset_capture: got valid=%b data=%h expected 1 9abc", result_valid, result_data);
    end
    @(negedge clk);
    start = 1'b0;
    wait_phase(1);
    wait_phase(7);
    checks++;
    if ({busy, array_in} !== {1'b1, 8'h30}) begin
      errors++;
      $display("FAIL pre_reset_stream: got busy=%b in=%h expected 1 30", busy, array_in);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, array_in, result_data, result_valid, overflow, frame_phase} !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b in=%h data=%h valid=%b ovf=%b ph=%0d expected all zero",
               busy, array_in, result_data, result_valid, overflow, frame_phase);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({frame_phase, busy, array_in} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_release: got ph=%0d busy=%b in=%h expected 0 0 00", frame_phase, busy, array_in);
    end
    @(negedge clk);
    checks++;
    if (frame_phase !== 5'd1) begin
      errors++;
      $display("FAIL midreset_phase_run: got %0d expected 1", frame_phase);
    end
    pulse_start();
    wait_phase(1);
    checks++;
    if ({busy, array_in} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL midreset_staging_cleared: got busy=%b in=%h expected 1 00", busy, array_in);
    end
    @(negedge clk);
    checks++;
    if (array_in !== 8'h00) begin
      errors++;
      $display("FAIL midreset_staging_w1: got %h expected 00", array_in);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_double_buffer();
    test_back_to_back();
    test_capture_with_ready();
    test_idle_frames();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
